// File: rtl/spc_ctl.sv
// SPC (subroutine PC stack) controller: latches push/pop intent at decode,
// sequences read/write port strobes, tracks a shadow depth with sticky errors.
module spc_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        state_decode,
  input  logic        state_read,
  input  logic        state_alu,
  input  logic        state_write,
  input  logic        state_fetch,
  input  logic        ir_destspc,
  input  logic        ir_popj,
  input  logic        ir_call,
  input  logic        jcond,
  input  logic        n_inhibit,
  input  logic [31:0] l,
  input  logic [13:0] wpc,
  input  logic [13:0] ipc,
  input  logic [18:0] spco,
  output logic        spush,
  output logic        spcnt,
  output logic        srp,
  output logic        swp,
  output logic [18:0] spcw,
  output logic [18:0] spcl,
  output logic [5:0]  depth,
  output logic        spc_ovf,
  output logic        spc_unf,
  input  logic        clr_err
);

  localparam int unsigned PC_W    = 14;
  localparam int unsigned SPC_W   = 19;
  localparam int unsigned DEPTH_W = 6;
  localparam int unsigned MAX_D   = 32;

  logic               r_push_p;
  logic               r_pop_p;
  logic               r_src_l;
  logic [PC_W-1:0]    r_ret;
  logic               r_spush;
  logic               r_spcnt;
  logic [SPC_W-1:0]   r_spcl;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  logic w_push_req;
  logic w_pop_req;
  logic w_full;
  logic w_empty;
  logic w_ovf_set;
  logic w_unf_set;
  logic w_l_unused;

  // Push wins over pop when a microinstruction requests both
  assign w_push_req = ~n_inhibit & (ir_destspc | (ir_call & jcond));
  assign w_pop_req  = ~n_inhibit & ir_popj & ~w_push_req;

  assign w_full    = (r_depth == DEPTH_W'(MAX_D));
  assign w_empty   = (r_depth == '0);
  assign w_ovf_set = state_fetch & r_push_p & w_full;
  assign w_unf_set = state_fetch & r_pop_p & w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_push_p <= 1'b0;
      r_pop_p  <= 1'b0;
      r_src_l  <= 1'b0;
      r_ret    <= '0;
      r_spush  <= 1'b0;
      r_spcnt  <= 1'b0;
      r_spcl   <= '0;
      r_depth  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (state_decode) begin
        r_push_p <= w_push_req;
        r_pop_p  <= w_pop_req;
        r_src_l  <= ir_destspc;
        r_ret    <= n_inhibit ? wpc : ipc;
        r_spush  <= w_push_req;
        r_spcnt  <= w_push_req | w_pop_req;
      end
      if (state_alu && r_pop_p) begin
        r_spcl <= spco;
      end
      // Depth saturates at both ends; the error flags record the attempt
      if (state_fetch) begin
        if (r_push_p && !w_full) begin
          r_depth <= r_depth + DEPTH_W'(1);
        end else if (r_pop_p && !w_empty) begin
          r_depth <= r_depth - DEPTH_W'(1);
        end
      end
      r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
      r_unf <= w_unf_set | (r_unf & ~clr_err);
    end
  end

  assign spush   = r_spush;
  assign spcnt   = r_spcnt;
  assign srp     = state_read & r_pop_p;
  assign swp     = state_write & r_push_p;
  assign spcw    = r_src_l ? l[SPC_W-1:0] : SPC_W'(r_ret);
  assign spcl    = r_spcl;
  assign depth   = r_depth;
  assign spc_ovf = r_ovf;
  assign spc_unf = r_unf;

  assign w_l_unused = ^l[31:SPC_W];

endmodule

// File: tb/tb_spc_ctl.sv
// Bench for spc_ctl: instruction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized instructions.
module tb_spc_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        state_decode, state_read, state_alu, state_write, state_fetch;
  logic        ir_destspc, ir_popj, ir_call, jcond, n_inhibit;
  logic [31:0] l;
  logic [13:0] wpc, ipc;
  logic [18:0] spco;
  logic        spush, spcnt, srp, swp;
  logic [18:0] spcw, spcl;
  logic [5:0]  depth;
  logic        spc_ovf, spc_unf, clr_err;

  int vectors = 0;
  int miscompares = 0;

  spc_ctl dut (
    .clk(clk), .reset(reset),
    .state_decode(state_decode), .state_read(state_read), .state_alu(state_alu),
    .state_write(state_write), .state_fetch(state_fetch),
    .ir_destspc(ir_destspc), .ir_popj(ir_popj), .ir_call(ir_call), .jcond(jcond),
    .n_inhibit(n_inhibit), .l(l), .wpc(wpc), .ipc(ipc), .spco(spco),
    .spush(spush), .spcnt(spcnt), .srp(srp), .swp(swp), .spcw(spcw), .spcl(spcl),
    .depth(depth), .spc_ovf(spc_ovf), .spc_unf(spc_unf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: instruction intent plus a saturating integer depth
  bit          m_valid = 0;
  bit          m_push, m_pop, m_srcl, m_ovf, m_unf;
  logic [13:0] m_ret;
  logic [18:0] m_spcl;
  int          m_depth;
  bit          ovf_hit, unf_hit;
  int          n_swp = 0, n_srp = 0;
  logic [18:0] last_wr = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_push = 0; m_pop = 0; m_srcl = 0; m_ret = '0;
      m_spcl = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
    end else if (m_valid) begin
      ovf_hit = state_fetch && m_push && m_depth == 32;
      unf_hit = state_fetch && m_pop && m_depth == 0;
      if (state_fetch && m_push) m_depth = (m_depth < 32) ? m_depth + 1 : 32;
      else if (state_fetch && m_pop) m_depth = (m_depth > 0) ? m_depth - 1 : 0;
      if (state_alu && m_pop) m_spcl = spco;
      m_ovf = ovf_hit || (m_ovf && !clr_err);
      m_unf = unf_hit || (m_unf && !clr_err);
      if (state_decode) begin
        m_push = !n_inhibit && (ir_destspc || (ir_call && jcond));
        m_pop  = !n_inhibit && ir_popj && !m_push;
        m_srcl = ir_destspc;
        m_ret  = n_inhibit ? wpc : ipc;
      end
    end
    #1;
    if (m_valid) begin
      chk("spush", 32'(spush), 32'(m_push));
      chk("spcnt", 32'(spcnt), 32'(m_push | m_pop));
      chk("srp", 32'(srp), 32'(state_read & m_pop));
      chk("swp", 32'(swp), 32'(state_write & m_push));
      chk("spcw", 32'(spcw), m_srcl ? 32'(l[18:0]) : 32'(m_ret));
      chk("spcl", 32'(spcl), 32'(m_spcl));
      chk("depth", 32'(depth), 32'(m_depth));
      chk("spc_ovf", 32'(spc_ovf), 32'(m_ovf));
      chk("spc_unf", 32'(spc_unf), 32'(m_unf));
      chk("srp_swp_excl", 32'(srp & swp), 32'd0);
      if (swp) begin n_swp++; last_wr = spcw; end
      if (srp) n_srp++;
    end
  end

  bit          spco_fix = 0;
  logic [18:0] spco_val = '0;
  always @(negedge clk) spco = spco_fix ? spco_val : 19'($urandom);

  bit rnd_clr   = 0;
  bit fetch_clr = 0;

  task automatic set_phase(input int ph);
    state_decode = (ph == 0);
    state_read   = (ph == 1);
    state_alu    = (ph == 2);
    state_write  = (ph == 3);
    state_fetch  = (ph == 4);
  endtask

  // Non-decode cycles scramble the IR fields: only decode-time values matter
  task automatic drive(input int ph, input logic [31:0] lv);
    @(negedge clk);
    set_phase(ph);
    {ir_destspc, ir_popj, ir_call, jcond, n_inhibit} = 5'($urandom);
    l = (ph == 3) ? lv : $urandom;
    clr_err = (ph == 4 && fetch_clr) || (rnd_clr && $urandom_range(0, 15) == 0);
  endtask

  task automatic instr(input bit dest, input bit popj, input bit call, input bit jc,
                       input bit inh, input logic [31:0] lv, input logic [13:0] ip,
                       input int gap_max);
    @(negedge clk);
    set_phase(0);
    ir_destspc = dest; ir_popj = popj; ir_call = call; jcond = jc; n_inhibit = inh;
    ipc = ip; wpc = ip - 14'd1; l = $urandom;
    clr_err = rnd_clr && $urandom_range(0, 15) == 0;
    for (int ph = 1; ph <= 4; ph++) begin
      repeat ($urandom_range(0, gap_max)) drive(5, 32'd0);
      drive(ph, lv);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; set_phase(5); clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int sw0, sr0;

  initial begin
    reset = 1'b1; set_phase(5);
    {ir_destspc, ir_popj, ir_call, jcond, n_inhibit, clr_err} = '0;
    l = '0; ipc = '0; wpc = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_spcw", 32'(spcw), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_spcl", 32'(spcl), 32'd0);
    chk("rst_spcnt", 32'(spcnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Call pushes the return address
    sw0 = n_swp;
    instr(0, 0, 1, 1, 0, 32'd0, 14'h0123, 0);
    chk("call_swp_cnt", 32'(n_swp - sw0), 32'd1);
    chk("call_wdata", 32'(last_wr), 32'h00123);
    chk("call_depth", 32'(depth), 32'd1);
    chk("call_spush", 32'(spush), 32'd1);

    // Push of L data, then popj returns it through spcl
    instr(1, 0, 0, 0, 0, 32'hFFF7_ABCD, 14'h0200, 1);
    chk("destspc_wdata", 32'(last_wr), 32'h7ABCD);
    chk("destspc_depth", 32'(depth), 32'd2);
    spco_fix = 1; spco_val = 19'h7ABCD;
    sr0 = n_srp;
    instr(0, 1, 0, 0, 0, 32'd0, 14'h0300, 1);
    spco_fix = 0;
    chk("popj_srp_cnt", 32'(n_srp - sr0), 32'd1);
    chk("popj_spcl", 32'(spcl), 32'h7ABCD);
    chk("popj_depth", 32'(depth), 32'd1);

    // Underflow on empty pop, then clear
    instr(0, 1, 0, 0, 0, 32'd0, 14'h0301, 0);
    chk("pop_to0_unf", 32'(spc_unf), 32'd0);
    instr(0, 1, 0, 0, 0, 32'd0, 14'h0302, 0);
    chk("unf_set", 32'(spc_unf), 32'd1);
    chk("unf_depth", 32'(depth), 32'd0);
    drive(5, 32'd0); clr_err = 1'b1;
    drive(5, 32'd0);
    #7;
    chk("unf_cleared", 32'(spc_unf), 32'd0);

    // destspc and popj together: push only
    sw0 = n_swp; sr0 = n_srp;
    instr(1, 1, 0, 0, 0, 32'h0000_1111, 14'h0400, 0);
    chk("both_swp", 32'(n_swp - sw0), 32'd1);
    chk("both_srp", 32'(n_srp - sr0), 32'd0);
    chk("both_depth", 32'(depth), 32'd1);

    // 33 pushes from empty saturate at 32 with overflow
    do_reset();
    for (int i = 0; i < 32; i++) instr(0, 0, 1, 1, 0, 32'd0, 14'(i), 0);
    chk("d32_depth", 32'(depth), 32'd32);
    chk("d32_no_ovf", 32'(spc_ovf), 32'd0);
    instr(0, 0, 1, 1, 0, 32'd0, 14'h0033, 0);
    chk("ovf_set", 32'(spc_ovf), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd32);
    drive(5, 32'd0); clr_err = 1'b1;
    drive(5, 32'd0);
    #7;
    chk("ovf_cleared", 32'(spc_ovf), 32'd0);
    chk("ovf_clr_depth", 32'(depth), 32'd32);
    fetch_clr = 1;
    instr(0, 0, 1, 1, 0, 32'd0, 14'h0034, 0);
    fetch_clr = 0;
    chk("set_beats_clr", 32'(spc_ovf), 32'd1);

    // Inhibited call: nothing moves, ret comes from wpc
    sw0 = n_swp;
    instr(0, 0, 1, 1, 1, 32'd0, 14'h0abc, 0);
    chk("inh_spcnt", 32'(spcnt), 32'd0);
    chk("inh_swp", 32'(n_swp - sw0), 32'd0);
    chk("inh_ret_wpc", 32'(spcw), 32'h00abb);
    chk("inh_depth", 32'(depth), 32'd32);

    // Reset during the alu cycle of a pop
    spco_fix = 1; spco_val = 19'h15555;
    instr(0, 1, 0, 0, 0, 32'd0, 14'h0500, 0);
    chk("pre_rst_spcl", 32'(spcl), 32'h15555);
    @(negedge clk); set_phase(0);
    {ir_destspc, ir_popj, ir_call, jcond, n_inhibit} = 5'b01000;
    drive(1, 32'd0);
    drive(2, 32'd0); reset = 1'b1; l = '0; ipc = '0;
    @(posedge clk); #2;
    chk("mid_rst_spcl", 32'(spcl), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_spcnt", 32'(spcnt), 32'd0);
    chk("mid_rst_ovf", 32'(spc_ovf), 32'd0);
    @(negedge clk); reset = 1'b0;
    drive(3, 32'd0);
    drive(4, 32'd0);
    @(posedge clk); #2;
    chk("post_rst_unf", 32'(spc_unf), 32'd0);
    chk("post_rst_depth", 32'(depth), 32'd0);
    spco_fix = 0;

    // Randomized instruction stream with gaps, clears and rare resets
    rnd_clr = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      instr(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
            $urandom, 14'($urandom), 2);
    end
    rnd_clr = 0;
    drive(5, 32'd0);
    @(posedge clk); #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
